alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Sequencing stage directly upstream of the combinational ALU.
- Accepts one operation request per handshake and reads operands from an internal 32x32 register file, or takes op2 from an immediate.
- Drives the ALU's op1/op2/oprn inputs, captures the ALU result and writes it back to the destination register.
- One operation in flight at a time; fixed latency.

Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH).
- REG_ADDR_WIDTH, 5, register index width; the file has 2**REG_ADDR_WIDTH entries.
- OPRN_WIDTH, 6, ALU operation code width (matches `ALU_OPRN_WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_oprn  input  OPRN_WIDTH  ALU operation code: 0x1 add … 0x9 slt.
- req_rs1  input  REG_ADDR_WIDTH  source register for op1.
- req_rs2  input  REG_ADDR_WIDTH  source register for op2 (ignored if req_imm_en).
- req_rd  input  REG_ADDR_WIDTH  destination register.
- req_imm_en  input  1  op2 = req_imm instead of register rs2.
- req_imm  input  DATA_WIDTH  immediate operand.
- alu_op1  output  DATA_WIDTH  to ALU op1.
- alu_op2  output  DATA_WIDTH  to ALU op2.
- alu_oprn  output  OPRN_WIDTH  to ALU oprn.
- alu_result  input  DATA_WIDTH  from ALU result (combinational).
- done  output  1  one-cycle pulse: operation complete.
- done_err  output  1  valid with done; illegal oprn, no write-back.
- done_result  output  DATA_WIDTH  result written (valid with done; held until next done).

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; all registers incl. file =0; alu_op1/alu_op2/alu_oprn=0; done=0, done_err=0, done_result=0; req_ready=1 after release.
- Reset mid-operation aborts it with no write-back and no done pulse.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE. Every state except IDLE lasts exactly one cycle.
- IDLE: req_ready=1. On an edge with req_valid&req_ready, latch oprn/rs1/rs2/rd/imm_en/imm and go to READ. Without req_valid, stay in IDLE.
- READ: register alu_op1=RF[rs1]; alu_op2 = imm_en ? imm : RF[rs2]; alu_oprn=oprn. Go to EXEC.
- EXEC: the ALU inputs are stable for the whole cycle. At the closing edge, capture alu_result into an internal result register. Go to WB.
- WB:
  - If oprn is in 0x01..0x09: RF[rd] = result (unless rd==0), done_result = result, done_err = 0.
  - Otherwise: no write, done_err=1, done_result unchanged.
  - done=1 for this cycle only.
  - Go to IDLE; alu_oprn returns to 0.
- Latency: accept edge to done high = 3 cycles. Throughput: one operation per 4 cycles.
- Register 0: always reads 0; writes to it are discarded, but done_result still reports the computed value.
- No hazards: single issue, and write-back completes before the next READ.
- req_* inputs are ignored outside IDLE.
- req_valid held high continuously: a new request is accepted on every IDLE cycle.
- Widths: the ALU does all arithmetic; this block does no arithmetic, only mux/register. Illegal-oprn detection is an unsigned range compare.

Decomposition:
- Shared package / prj_definition: DATA_WIDTH, REG_ADDR_WIDTH, OPRN_WIDTH; ALU opcode constants OPRN_ADD=0x01 … OPRN_SLT=0x09; FSM state encodings (2-bit IDLE/READ/EXEC/WB).
- Sub-module: alu_exec_regfile.
  - 2 async read ports, 1 sync write port, r0 hardwired to zero.
  - Asynchronous active-low reset clears all entries.
- The bench instantiates alu_exec_seq together with the existing ALU to close the loop.

Test Plan:
1. Reset, then req {oprn=0x01, rs1=0, rd=1, imm_en=1, imm=5} -> done 3 cycles after accept, done_result=5, RF[1]=5; req_ready low for 3 cycles.
2. Load r1=5 and r2=7 via the imm path, then {oprn=0x02, rs1=1, rs2=2, rd=3} -> done_result=0xFFFFFFFE. Then {oprn=0x09, rs1=1, rs2=2, rd=4} -> done_result=1.
3. {oprn=0x0A, rd=5} -> done=1, done_err=1, RF[5] remains 0, done_result unchanged from the previous operation.
4. {oprn=0x01, rs1=0, imm_en=1, imm=0x1234, rd=0} -> done_result=0x1234; a following read of r0 as rs1 yields alu_op1=0.
5. Assert RST low during EXEC of {add, imm=9, rd=6} -> outputs 0 immediately, RF[6]=0, no done pulse; after release req_ready=1.
6. req_valid held high with 3 back-to-back add-imm requests (imm 1, 2, 3 to rd 1, 2, 3) -> done pulses exactly 4 cycles apart; RF[1..3]=1, 2, 3.

Source files
------------

// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the ALU sequencing stage: widths, ALU opcodes,
// FSM state encodings and the legal-opcode check.
package alu_exec_seq_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int OPRN_WIDTH     = 6;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    // ALU operation codes understood by the downstream ALU
    localparam logic [OPRN_WIDTH-1:0] OPRN_ADD = 6'h01;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SUB = 6'h02;
    localparam logic [OPRN_WIDTH-1:0] OPRN_MUL = 6'h03;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SHR = 6'h04;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SHL = 6'h05;
    localparam logic [OPRN_WIDTH-1:0] OPRN_AND = 6'h06;
    localparam logic [OPRN_WIDTH-1:0] OPRN_OR  = 6'h07;
    localparam logic [OPRN_WIDTH-1:0] OPRN_NOR = 6'h08;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLT = 6'h09;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // Legal opcodes form one contiguous unsigned range
    function automatic logic oprn_legal(input logic [OPRN_WIDTH-1:0] oprn);
        return (oprn >= OPRN_ADD) && (oprn <= OPRN_SLT);
    endfunction

endpackage

// File: rtl/alu_exec_seq_if.sv
// Request, ALU and completion signals of the sequencing stage.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while the stage is idle,
// and req_* fields are don't-care whenever no transfer takes place.
interface alu_exec_seq_if;
    import alu_exec_seq_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [OPRN_WIDTH-1:0]     req_oprn;
    logic [REG_ADDR_WIDTH-1:0] req_rs1;
    logic [REG_ADDR_WIDTH-1:0] req_rs2;
    logic [REG_ADDR_WIDTH-1:0] req_rd;
    logic                      req_imm_en;
    logic [DATA_WIDTH-1:0]     req_imm;
    logic [DATA_WIDTH-1:0]     alu_op1;
    logic [DATA_WIDTH-1:0]     alu_op2;
    logic [OPRN_WIDTH-1:0]     alu_oprn;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      done;
    logic                      done_err;
    logic [DATA_WIDTH-1:0]     done_result;
    logic [1:0]                state_dbg;

    // Upstream requester plus the ALU that feeds alu_result back
    modport master (
        output req_valid, req_oprn, req_rs1, req_rs2, req_rd, req_imm_en, req_imm,
        output alu_result,
        input  req_ready, alu_op1, alu_op2, alu_oprn,
        input  done, done_err, done_result, state_dbg
    );

    // The sequencing stage itself
    modport slave (
        input  req_valid, req_oprn, req_rs1, req_rs2, req_rd, req_imm_en, req_imm,
        input  alu_result,
        output req_ready, alu_op1, alu_op2, alu_oprn,
        output done, done_err, done_result, state_dbg
    );

endinterface

// File: rtl/alu_exec_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register 0 reads as zero and ignores writes.
module alu_exec_regfile
    import alu_exec_seq_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0]     rdata1,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0]     rdata2,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Storage: cleared by reset, written on the rising edge, r0 never written
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports are combinational; r0 is forced to zero at the port
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequencing stage in front of the combinational ALU. Runs one operation at
// a time through IDLE -> READ -> EXEC -> WB, then writes the result back.
module alu_exec_seq
    import alu_exec_seq_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    alu_exec_seq_if.slave bus
);

    logic [1:0]                state;
    logic [OPRN_WIDTH-1:0]     oprn_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      imm_en_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [DATA_WIDTH-1:0]     rf_rdata1;
    logic [DATA_WIDTH-1:0]     rf_rdata2;
    logic                      legal;
    logic                      rf_we;

    assign legal         = oprn_legal(oprn_q);
    assign rf_we         = (state == ST_WB) && legal;
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.state_dbg = state;

    alu_exec_regfile u_regfile (
        .CLK    (CLK),
        .RST    (RST),
        .raddr1 (rs1_q),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2_q),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rd_q),
        .wdata  (result_q)
    );

    // FSM, request latch, ALU input drive, result capture and completion
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= ST_IDLE;
            oprn_q          <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            imm_en_q        <= 1'b0;
            imm_q           <= '0;
            result_q        <= '0;
            bus.alu_op1     <= '0;
            bus.alu_op2     <= '0;
            bus.alu_oprn    <= '0;
            bus.done        <= 1'b0;
            bus.done_err    <= 1'b0;
            bus.done_result <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.done_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        oprn_q   <= bus.req_oprn;
                        rs1_q    <= bus.req_rs1;
                        rs2_q    <= bus.req_rs2;
                        rd_q     <= bus.req_rd;
                        imm_en_q <= bus.req_imm_en;
                        imm_q    <= bus.req_imm;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    bus.alu_op1  <= rf_rdata1;
                    bus.alu_op2  <= imm_en_q ? imm_q : rf_rdata2;
                    bus.alu_oprn <= oprn_q;
                    state        <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q <= bus.alu_result;
                    state    <= ST_WB;
                end
                default: begin
                    // write-back itself goes through rf_we this same edge
                    bus.done     <= 1'b1;
                    bus.done_err <= !legal;
                    if (legal) begin
                        bus.done_result <= result_q;
                    end
                    bus.alu_oprn <= '0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq, closed around a behavioural ALU.
module tb_alu_exec_seq;
    import alu_exec_seq_pkg::*;

    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    alu_exec_seq_if bus ();

    alu_exec_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---- clock/reset ----
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---- behavioural ALU closing the loop ----
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_oprn)
            OPRN_ADD: bus.alu_result = bus.alu_op1 + bus.alu_op2;
            OPRN_SUB: bus.alu_result = bus.alu_op1 - bus.alu_op2;
            OPRN_MUL: bus.alu_result = bus.alu_op1 * bus.alu_op2;
            OPRN_SHR: bus.alu_result = bus.alu_op1 >> bus.alu_op2;
            OPRN_SHL: bus.alu_result = bus.alu_op1 << bus.alu_op2;
            OPRN_AND: bus.alu_result = bus.alu_op1 & bus.alu_op2;
            OPRN_OR:  bus.alu_result = bus.alu_op1 | bus.alu_op2;
            OPRN_NOR: bus.alu_result = ~(bus.alu_op1 | bus.alu_op2);
            OPRN_SLT: bus.alu_result = {31'd0, $signed(bus.alu_op1) < $signed(bus.alu_op2)};
            default:  bus.alu_result = '0;
        endcase
    end

    // ---- driver tasks ----
    task automatic drive_idle();
        bus.req_valid  = 1'b0;
        bus.req_oprn   = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_rd     = '0;
        bus.req_imm_en = 1'b0;
        bus.req_imm    = '0;
    endtask

    // One request from IDLE; reports latency, ready-low cycles, op1 seen in
    // EXEC and the completion fields.
    task automatic do_req(input logic [5:0] oprn, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic imm_en, input logic [31:0] imm,
                          output int lat, output int ready_low,
                          output logic [31:0] op1_exec,
                          output logic [31:0] res, output logic err);
        logic got;
        got = 1'b0;
        lat = -1;
        ready_low = 0;
        op1_exec = 'x;
        res = 'x;
        err = 1'bx;
        @(negedge CLK);
        bus.req_valid  = 1'b1;
        bus.req_oprn   = oprn;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_rd     = rd;
        bus.req_imm_en = imm_en;
        bus.req_imm    = imm;
        @(posedge CLK);
        for (int n = 0; n < 12; n++) begin
            @(negedge CLK);
            if (n == 0) drive_idle();
            if (!bus.req_ready) ready_low++;
            if (n == 1) op1_exec = bus.alu_op1;
            if (bus.done) begin
                lat = n;
                res = bus.done_result;
                err = bus.done_err;
                got = 1'b1;
                break;
            end
            @(posedge CLK);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_timeout: oprn=%0h no done within 12 cycles, required done", oprn);
        end
    endtask

    // Reads a register through the datapath: r[k] + 0 into r0
    task automatic read_reg(input logic [4:0] k, output logic [31:0] val);
        int l, rl;
        logic [31:0] o1;
        logic e;
        do_req(OPRN_ADD, k, 5'd0, 5'd0, 1'b1, 32'd0, l, rl, o1, val, e);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        RST = 1'b0;
        drive_idle();
        repeat (3) @(negedge CLK);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.done !== 1'b0 || bus.done_err !== 1'b0) begin bad++; $display("FAIL reset_done: got %b/%b want 0/0", bus.done, bus.done_err); end
        total++; if (bus.done_result !== 32'd0) begin bad++; $display("FAIL reset_done_result: got %h want 0", bus.done_result); end
        total++; if (bus.alu_op1 !== 32'd0 || bus.alu_op2 !== 32'd0 || bus.alu_oprn !== 6'd0) begin bad++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", bus.alu_op1, bus.alu_op2, bus.alu_oprn); end
        total++; if (bus.state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_latency();
        int lat, rl;
        logic [31:0] o1, res, v;
        logic err;
        do_req(OPRN_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, lat, rl, o1, res, err);
        total++; if (lat !== 3) begin bad++; $display("FAIL latency: got %0d want 3", lat); end
        total++; if (rl !== 3) begin bad++; $display("FAIL ready_low_cycles: got %0d want 3", rl); end
        total++; if (res !== 32'd5 || err !== 1'b0) begin bad++; $display("FAIL add_imm: got %h err=%b want 5 err=0", res, err); end
        @(negedge CLK);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", bus.done); end
        read_reg(5'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL rf1_after_add: got %h want 5", v); end
    endtask

    task automatic test_reg_ops();
        int lat, rl;
        logic [31:0] o1, res;
        logic err;
        do_req(OPRN_ADD, 5'd0, 5'd0, 5'd2, 1'b1, 32'd7, lat, rl, o1, res, err);
        do_req(OPRN_SUB, 5'd1, 5'd2, 5'd3, 1'b0, 32'hDEAD_BEEF, lat, rl, o1, res, err);
        total++; if (res !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_reg: got %h want fffffffe", res); end
        total++; if (o1 !== 32'd5) begin bad++; $display("FAIL sub_op1: got %h want 5", o1); end
        do_req(OPRN_SLT, 5'd1, 5'd2, 5'd4, 1'b0, 32'd0, lat, rl, o1, res, err);
        total++; if (res !== 32'd1) begin bad++; $display("FAIL slt_reg: got %h want 1", res); end
    endtask

    task automatic test_illegal();
        int lat, rl;
        logic [31:0] o1, res, v;
        logic err;
        do_req(6'h0A, 5'd1, 5'd2, 5'd5, 1'b0, 32'd0, lat, rl, o1, res, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1", err); end
        total++; if (res !== 32'd1) begin bad++; $display("FAIL illegal_result_held: got %h want 1", res); end
        total++; if (lat !== 3) begin bad++; $display("FAIL illegal_latency: got %0d want 3", lat); end
        read_reg(5'd5, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL illegal_no_write: got %h want 0", v); end
        read_reg(5'd3, v);
        total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rf3_sub: got %h want fffffffe", v); end
    endtask

    task automatic test_r0();
        int lat, rl;
        logic [31:0] o1, res;
        logic err;
        do_req(OPRN_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 32'h1234, lat, rl, o1, res, err);
        total++; if (res !== 32'h1234) begin bad++; $display("FAIL r0_report: got %h want 1234", res); end
        do_req(OPRN_ADD, 5'd0, 5'd0, 5'd7, 1'b0, 32'd0, lat, rl, o1, res, err);
        total++; if (o1 !== 32'd0) begin bad++; $display("FAIL r0_reads_zero: got %h want 0", o1); end
        total++; if (res !== 32'd0) begin bad++; $display("FAIL r0_sum: got %h want 0", res); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] v;
        logic saw_done;
        @(negedge CLK);
        bus.req_valid  = 1'b1;
        bus.req_oprn   = OPRN_ADD;
        bus.req_rs1    = 5'd1;
        bus.req_rd     = 5'd6;
        bus.req_imm_en = 1'b1;
        bus.req_imm    = 32'd9;
        @(posedge CLK);            // accept, now READ
        @(negedge CLK);
        drive_idle();
        @(posedge CLK);            // now EXEC
        #2;
        total++; if (bus.state_dbg !== ST_EXEC || bus.alu_op2 !== 32'd9) begin bad++; $display("FAIL pre_abort_exec: got st=%0d op2=%h want 2/9", bus.state_dbg, bus.alu_op2); end
        RST = 1'b0;
        #1;
        total++; if (bus.alu_op1 !== 32'd0 || bus.alu_op2 !== 32'd0 || bus.alu_oprn !== 6'd0) begin bad++; $display("FAIL abort_alu: got %h %h %h want 0 0 0", bus.alu_op1, bus.alu_op2, bus.alu_oprn); end
        total++; if (bus.done_result !== 32'd0 || bus.done !== 1'b0) begin bad++; $display("FAIL abort_done: got %h/%b want 0/0", bus.done_result, bus.done); end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            if (bus.done) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got 1 want 0"); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", bus.req_ready); end
        read_reg(5'd6, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL abort_no_write: got %h want 0", v); end
        read_reg(5'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_clears_rf: got %h want 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] v, e;
        int acc, ndone, last_done;
        logic will_accept;
        acc = 0;
        ndone = 0;
        last_done = -1;
        @(negedge CLK);
        for (int c = 0; c < 16; c++) begin
            if (acc < 3) begin
                bus.req_valid  = 1'b1;
                bus.req_oprn   = OPRN_ADD;
                bus.req_rs1    = 5'd0;
                bus.req_rd     = 5'(acc + 1);
                bus.req_imm_en = 1'b1;
                bus.req_imm    = 32'(acc + 1);
            end else begin
                drive_idle();
            end
            will_accept = bus.req_valid && bus.req_ready;
            @(posedge CLK);
            if (will_accept) begin
                exp_q.push_back(32'(acc + 1));
                acc++;
            end
            @(negedge CLK);
            if (bus.done) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                total++; if (bus.done_result !== e) begin bad++; $display("FAIL b2b_result: got %h want %h", bus.done_result, e); end
                if (last_done >= 0) begin
                    total++; if (c - last_done !== 4) begin bad++; $display("FAIL b2b_spacing: got %0d want 4", c - last_done); end
                end
                last_done = c;
                ndone++;
            end
        end
        total++; if (acc !== 3 || ndone !== 3) begin bad++; $display("FAIL b2b_count: got acc=%0d done=%0d want 3/3", acc, ndone); end
        for (int k = 1; k <= 3; k++) begin
            read_reg(5'(k), v);
            total++; if (v !== 32'(k)) begin bad++; $display("FAIL b2b_rf%0d: got %h want %h", k, v, 32'(k)); end
        end
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_latency();
        test_reg_ops();
        test_illegal();
        test_r0();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
